// File: rtl/ktane_bus_master_if.sv
// Host command/response handshake plus single-clock peripheral bus for ktane_bus_master.
interface ktane_bus_master_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] q;

    // Bus initiator side.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, q,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output data, write_addr, read_addr, we, re
    );

    // Host sequencer and peripheral side.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, q,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  data, write_addr, read_addr, we, re
    );
endinterface

// File: rtl/ktane_bus_master.sv
// Bus initiator for the bomb controller memory map: queues host commands, runs one
// bus transaction at a time and returns read data / error responses in order.
// Optional feature macro: KTANE_BUS_WRITE_RSP_EN (writes also return a response).
module ktane_bus_master #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned CMD_DEPTH    = 4
) (
    input logic                clk,
    input logic                rst_n,
    ktane_bus_master_if.master bus
);
    localparam int unsigned PTR_W   = $clog2(CMD_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned LAT_W   = 3;
    localparam int unsigned ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] ERR_BASE = ADDR_WIDTH'(32'hFFFC);
    localparam logic [ADDR_WIDTH-1:0] MORSE_LO = ADDR_WIDTH'(32'hD998);
    localparam logic [ADDR_WIDTH-1:0] MORSE_HI = ADDR_WIDTH'(32'hE663);

    typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [ENTRY_W-1:0]    mem [CMD_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  cmd_ready_q;
    logic                  push, pop;
    logic                  head_write, head_err;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;

    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_WIDTH-1:0] cur_wdata_q, cur_wdata_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  err_wait_q, err_wait_d;
    logic                  we_q, we_d, re_q, re_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    assign push    = bus.cmd_valid && cmd_ready_q;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    assign {head_write, head_addr, head_wdata} = mem[rd_ptr_q];

    // Top four words are unmapped; morse region has no readback path.
    assign head_err = (head_addr >= ERR_BASE) ||
                      (!head_write && (head_addr >= MORSE_LO) && (head_addr <= MORSE_HI));

    // Command FIFO storage.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
        end
    end

    // FIFO pointers, occupancy and registered ready (no bypass when full).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q     <= count_d;
            cmd_ready_q <= (count_d != CNT_W'(CMD_DEPTH));
        end
    end

    // FSM state plus registered bus and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            cur_wdata_q <= '0;
            lat_q       <= '0;
            err_wait_q  <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            data_q      <= '0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            cur_wdata_q <= cur_wdata_d;
            lat_q       <= lat_d;
            err_wait_q  <= err_wait_d;
            we_q        <= we_d;
            re_q        <= re_d;
            data_q      <= data_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and next-output decode; strobes default low, addresses and data hold.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        cur_addr_d  = cur_addr_q;
        cur_wdata_d = cur_wdata_q;
        lat_d       = lat_q;
        err_wait_d  = err_wait_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        data_d      = data_q;
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop         = 1'b1;
                    cur_addr_d  = head_addr;
                    cur_wdata_d = head_wdata;
                    if (head_err) begin
                        // Errors spend one dead cycle in RESP so they surface two cycles after the pop.
                        state_d     = RESP;
                        err_wait_d  = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else if (head_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            WRITE: begin
                we_d    = 1'b1;
                waddr_d = cur_addr_q;
                data_d  = cur_wdata_q;
`ifdef KTANE_BUS_WRITE_RSP_EN
                state_d     = RESP;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
`else
                state_d = IDLE;
`endif
            end
            RD_ISSUE: begin
                re_d    = 1'b1;
                raddr_d = cur_addr_q;
                lat_d   = LAT_W'(READ_LATENCY - 1);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_q == '0) begin
                    rsp_rdata_d = bus.q;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d = IDLE;
                end else if (err_wait_q) begin
                    err_wait_d = 1'b0;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.we         = we_q;
    assign bus.re         = re_q;
    assign bus.data       = data_q;
    assign bus.write_addr = waddr_q;
    assign bus.read_addr  = raddr_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: doc/ktane_bus_master.md
# ktane_bus_master

Bus initiator for the bomb controller's memory-mapped space. It accepts read/write commands from the host-side sequencer through a valid/ready queue, drives the single-clock peripheral bus (`data`, `write_addr`, `read_addr`, `we`, `re`), waits out the fixed read latency of the RAM/peripheral output mux, and returns read data through a valid/ready response port. It is the driving end of the map that splits 0x0000–0xFFFB into RAM, button, keypad, morse, wires and extras regions.

## Interface
- `DATA_WIDTH`, 16, bus data width
- `ADDR_WIDTH`, 16, bus address width
- `READ_LATENCY`, 2, cycles from `re` assertion to valid `q` (1..7)
- `CMD_DEPTH`, 4, command FIFO entries (power of two, ≥2)

- `clk` in 1 — single clock, all logic on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `cmd_valid` in 1 — host command present
- `cmd_ready` out 1 — FIFO not full
- `cmd_write` in 1 — 1 = write, 0 = read
- `cmd_addr` in ADDR_WIDTH — target address
- `cmd_wdata` in DATA_WIDTH — write data
- `rsp_valid` out 1 — response present
- `rsp_ready` in 1 — host accepts response
- `rsp_rdata` out DATA_WIDTH — read data (0 for writes/errors)
- `rsp_err` out 1 — command targeted an unsupported address
- `data` out DATA_WIDTH — bus write data
- `write_addr` out ADDR_WIDTH — bus write address
- `read_addr` out ADDR_WIDTH — bus read address
- `we` out 1 — write strobe
- `re` out 1 — read strobe
- `q` in DATA_WIDTH — bus read data

## Operation
- Command FIFO: push on `cmd_valid && cmd_ready`. `cmd_ready = !full`, with no same-cycle bypass when full. A pop in the cycle the FIFO is full does not admit a push in that cycle.
- FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP.
- IDLE: if the FIFO is non-empty, pop the head and decode it:
  - Write at address ≥ 0xFFFC → RESP with `rsp_err=1`. No bus cycle is issued.
  - Read at address ≥ 0xFFFC, or in the morse region 0xD998–0xE663 (no readback path) → RESP with `rsp_err=1`. No bus cycle is issued.
  - Valid write → WRITE. Valid read → RD_ISSUE.
- WRITE: drive `we=1`, `write_addr`, `data` for exactly one cycle.
  - Without `KTANE_BUS_WRITE_RSP_EN`, return to IDLE.
  - With it, go to RESP with `rsp_rdata=0`, `rsp_err=0`.
- RD_ISSUE: drive `re=1` and `read_addr` for one cycle, load the latency counter with READ_LATENCY-1, go to RD_WAIT.
- RD_WAIT: `re=0`, `read_addr` held. Decrement the counter each cycle. At count 0, capture `q` into `rsp_rdata` and go to RESP.
- RESP: `rsp_valid=1`. Hold all response fields stable until `rsp_ready`, then go to IDLE.
- Ordering: strictly one transaction outstanding, responses in command order.
- Address outputs hold their last driven value between transactions, because the downstream decoder samples addresses every cycle. `data` holds its last value.
- Reset mid-transaction: the FIFO empties, the FSM goes to IDLE, and any in-flight read is dropped with no response.

## Timing
- Reset values:
  - `we=0`, `re=0`
  - `data=0`, `write_addr=0`, `read_addr=0`
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`
  - `cmd_ready=1`
- All bus outputs and response outputs are registered.
- Write, FIFO previously empty:
  - Command accepted at edge N.
  - Popped in IDLE at N+1.
  - `we` high during cycle N+2.
  - With the macro, `rsp_valid` is high from N+3.
- Read: `re` high one cycle. `q` is sampled READ_LATENCY cycles after the `re` edge. `rsp_valid` rises the following cycle.
- Error commands: `rsp_valid` rises 2 cycles after the pop.
- Back-to-back writes without the macro: one bus write every 2 cycles (IDLE/WRITE alternation).
- `rsp_valid` held with `rsp_ready=0`: the FSM stalls in RESP, and the FIFO continues accepting up to CMD_DEPTH entries.

## Configuration
- `KTANE_BUS_WRITE_RSP_EN`
  - Defined: every write produces a response (`rsp_rdata=0`, `rsp_err=0`), so the host can count completions.
  - Undefined: writes are posted and produce no response. Error responses for illegal addresses are still returned.

## Test plan
- Write 0x0043 to 0xF330 → `we` pulses one cycle with `write_addr=0xF330`, `data=0x0043`. With the macro, one response with `rsp_err=0`.
- Read 0x0010 with `q` model returning 0xBEEF READ_LATENCY cycles after `re` → `rsp_rdata=0xBEEF`, `rsp_err=0`, `re` high exactly one cycle.
- Read 0xDA00 and write 0xFFFE → two error responses, `rsp_err=1`, `rsp_rdata=0`. `we`/`re` never assert.
- Push 6 commands with `rsp_ready=0` and CMD_DEPTH=4 → `cmd_ready` drops after the 5th accepted command (4 queued plus 1 in RESP). Release `rsp_ready` → all responses arrive in order.
- Assert `rst_n=0` during RD_WAIT → all outputs return to reset values asynchronously. No `rsp_valid` appears after release.
- Read 0xC000 then write 0xC000 back-to-back → `read_addr` holds 0xC000 until the next read. The write strobe does not overlap `re`.
